// File: rtl/mem_access_unit.sv
// Load/store sequencer between the MEM stage and byte-addressed data memory.
// One request at a time; halfword stores become two byte writes.
module mem_access_unit #(
  parameter int READ_LATENCY = 1,
  parameter int ADDR_W       = 18
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_error,
  output logic [ADDR_W-1:0] mem_address,
  output logic [31:0]       mem_write_data,
  output logic              mem_read,
  output logic              mem_write,
  output logic              mem_byte_op,
  input  logic [31:0]       mem_read_data
);

  typedef enum logic [2:0] {IDLE, READ, WR0, WR1, RESP} state_t;

  localparam logic [2:0] LAT_INIT = 3'(READ_LATENCY);

  state_t            state_r;
  logic [1:0]        size_r;
  logic              unsigned_r;
  logic [ADDR_W-1:0] addr_r;
  logic [7:0]        hi_byte_r;
  logic              err_r;
  logic [2:0]        cnt_r;
  logic              req_err_s;

  function automatic logic access_illegal(input logic [1:0] size, input logic [1:0] low);
    case (size)
      2'b00:   access_illegal = 1'b0;
      2'b01:   access_illegal = low[0];
      2'b10:   access_illegal = (low != 2'b00);
      default: access_illegal = 1'b1;
    endcase
  endfunction

  function automatic logic [31:0] extend_load(input logic [31:0] data, input logic [1:0] size,
                                              input logic is_unsigned);
    logic fill;
    fill = 1'b0;
    case (size)
      2'b00: begin
        fill        = ~is_unsigned & data[7];
        extend_load = {{24{fill}}, data[7:0]};
      end
      2'b01: begin
        fill        = ~is_unsigned & data[15];
        extend_load = {{16{fill}}, data[15:0]};
      end
      default: extend_load = data;
    endcase
  endfunction

  assign req_err_s = access_illegal(req_size, req_addr[1:0]);

  // Sequencer FSM; every handshake and memory-side output is a flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r        <= IDLE;
      size_r         <= 2'b00;
      unsigned_r     <= 1'b0;
      addr_r         <= '0;
      hi_byte_r      <= 8'h00;
      err_r          <= 1'b0;
      cnt_r          <= 3'd0;
      req_ready      <= 1'b1;
      resp_valid     <= 1'b0;
      resp_rdata     <= 32'h0000_0000;
      resp_error     <= 1'b0;
      mem_address    <= '0;
      mem_write_data <= 32'h0000_0000;
      mem_read       <= 1'b0;
      mem_write      <= 1'b0;
      mem_byte_op    <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          resp_valid <= 1'b0;
          if (req_valid && req_ready) begin
            req_ready  <= 1'b0;
            size_r     <= req_size;
            unsigned_r <= req_unsigned;
            addr_r     <= req_addr;
            hi_byte_r  <= req_wdata[15:8];
            err_r      <= req_err_s;
            if (req_err_s) begin
              // Erroring requests idle one quiet cycle in WR0 so the response
              // lands one cycle after accept, with no strobe raised.
              state_r     <= WR0;
              mem_read    <= 1'b0;
              mem_write   <= 1'b0;
              mem_byte_op <= 1'b0;
            end else if (!req_write) begin
              state_r     <= READ;
              cnt_r       <= LAT_INIT;
              mem_read    <= 1'b1;
              mem_write   <= 1'b0;
              mem_byte_op <= 1'b0;
              mem_address <= req_addr;
            end else begin
              state_r        <= WR0;
              mem_read       <= 1'b0;
              mem_write      <= 1'b1;
              mem_address    <= req_addr;
              mem_byte_op    <= (req_size != 2'b10);
              mem_write_data <= (req_size == 2'b10) ? req_wdata : {24'h00_0000, req_wdata[7:0]};
            end
          end else begin
            req_ready   <= 1'b1;
            mem_read    <= 1'b0;
            mem_write   <= 1'b0;
            mem_byte_op <= 1'b0;
          end
        end
        READ: begin
          if (cnt_r == 3'd1) begin
            state_r    <= RESP;
            mem_read   <= 1'b0;
            resp_valid <= 1'b1;
            resp_error <= 1'b0;
            resp_rdata <= extend_load(mem_read_data, size_r, unsigned_r);
          end else begin
            cnt_r <= cnt_r - 3'd1;
          end
        end
        WR0: begin
          if (err_r) begin
            state_r    <= RESP;
            resp_valid <= 1'b1;
            resp_error <= 1'b1;
            resp_rdata <= 32'h0000_0000;
          end else if (size_r == 2'b01) begin
            state_r        <= WR1;
            mem_address    <= addr_r + ADDR_W'(1);
            mem_write_data <= {24'h00_0000, hi_byte_r};
          end else begin
            state_r     <= RESP;
            mem_write   <= 1'b0;
            mem_byte_op <= 1'b0;
            resp_valid  <= 1'b1;
            resp_error  <= 1'b0;
            resp_rdata  <= 32'h0000_0000;
          end
        end
        WR1: begin
          state_r     <= RESP;
          mem_write   <= 1'b0;
          mem_byte_op <= 1'b0;
          resp_valid  <= 1'b1;
          resp_error  <= 1'b0;
          resp_rdata  <= 32'h0000_0000;
        end
        RESP: begin
          state_r    <= IDLE;
          resp_valid <= 1'b0;
          req_ready  <= 1'b1;
        end
        default: begin
          state_r     <= IDLE;
          req_ready   <= 1'b1;
          resp_valid  <= 1'b0;
          mem_read    <= 1'b0;
          mem_write   <= 1'b0;
          mem_byte_op <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Load/store sequencer between the MIPS datapath's MEM stage and the data memory, which accepts byte or word accesses at an 18-bit byte address. The unit accepts one request at a time over a valid/ready handshake and checks alignment. It splits halfword stores into two byte writes, drives registered, glitch-free memory strobes, and returns zero- or sign-extended load data with a one-cycle response pulse.

## Interface
- READ_LATENCY, 1, cycles `mem_read` is held with a stable `mem_address` before `mem_read_data` is sampled; legal range 1–4.
- ADDR_W, 18, byte-address width.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  unit idle; a request is accepted when req_valid && req_ready at a rising edge.
- req_write  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 halfword, 10 word, 11 illegal.
- req_unsigned  in  1  loads only: 1 = zero-extend, 0 = sign-extend.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  32  store data, right-justified.
- resp_valid  out  1  one-cycle completion pulse; no backpressure.
- resp_rdata  out  32  extended load data; 0 for stores and errors.
- resp_error  out  1  misaligned or illegal size; valid with resp_valid.
- mem_address  out  ADDR_W  registered memory address.
- mem_write_data  out  32  registered memory write data.
- mem_read  out  1  registered read strobe.
- mem_write  out  1  registered write strobe.
- mem_byte_op  out  1  registered byte-operation select.
- mem_read_data  in  32  little-endian word starting at mem_address.

## Operation
- FSM states: IDLE, READ, WR0, WR1, RESP.
- IDLE: req_ready=1. On accept, latch all request fields.
  - Error check first: size 11, halfword with addr[0]=1, or word with addr[1:0]≠00 → RESP with error=1. No memory strobe is ever raised for an erroring request.
  - Load → READ; counter loaded with READ_LATENCY.
  - Store → WR0.
- READ: mem_read=1, mem_address=addr, mem_byte_op=0. Counter decrements each cycle.
  - When the counter reaches 1, capture and extend mem_read_data; go to RESP.
  - Byte: bits [7:0] extended to 32. Halfword: bits [15:0] extended to 32. Word: bits [31:0] unchanged.
  - Sign extension replicates bit 7 or bit 15. Zero extension fills with 0.
- WR0: mem_write=1, mem_address=addr.
  - Byte: mem_byte_op=1, mem_write_data[7:0]=wdata[7:0], then RESP.
  - Word: mem_byte_op=0, mem_write_data=wdata, then RESP.
  - Halfword: mem_byte_op=1, mem_write_data[7:0]=wdata[7:0], then WR1.
- WR1: mem_write=1, mem_byte_op=1, mem_address=addr+1, mem_write_data[7:0]=wdata[15:8]. Then RESP.
- RESP: resp_valid=1, req_ready=0. Next state is IDLE unconditionally.
- All memory-side outputs are flops. In IDLE and RESP: mem_read=mem_write=mem_byte_op=0, and mem_address/mem_write_data hold their last values.
- Unused mem_write_data bits are driven to 0 on byte writes.
- addr+1 is computed modulo 2^ADDR_W; wrap from 0x3FFFF to 0x00000 is legal.

## Timing
- Reset (async assert, sync deassert): state=IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_error=0, mem_read=0, mem_write=0, mem_byte_op=0, mem_address=0, mem_write_data=0.
- Reset mid-operation: strobes drop immediately, and the in-flight request is discarded with no response.
- Accept at edge E0. Response is high for one cycle:
  - Load: E0+L .. E0+L+1, where L=READ_LATENCY.
  - Byte or word store: E0+1 .. E0+2.
  - Halfword store: E0+2 .. E0+3.
  - Error: E0+1 .. E0+2.
- req_ready returns to 1 in the cycle after the resp_valid pulse.
- Back-to-back throughput for byte/word stores: one request every 3 cycles.
- req_valid while req_ready=0 is ignored; the requester must hold it until it is accepted.

## Test plan
- Reset with req_valid=1, then release → req_ready=1 and all outputs 0. A request presented on the first edge after release is accepted.
- Word store 0xDEADBEEF at 0x00010, then lw at 0x00010 (L=1) → a single mem_write cycle with byte_op=0. resp_rdata=0xDEADBEEF at E0+1, with no response before that.
- sh 0x0000A5C3 at 0x00021 → resp_error=1 and zero strobes. sh at 0x00020 → byte writes 0xC3@0x20 then 0xA5@0x21 on consecutive cycles. lh at 0x20 → 0xFFFFA5C3; lhu at 0x20 → 0x0000A5C3.
- lb with memory byte 0x80 → 0xFFFFFF80; lbu → 0x00000080. Repeat with READ_LATENCY=3 → mem_read held for exactly 3 cycles and resp_valid at E0+3.
- Assert rst_n low during WR1 of a halfword store → mem_write drops asynchronously, no resp_valid, and the unit is idle after release.
- Byte store at 0x3FFFF, then lbu at 0x3FFFF → address wrap is not exercised and data returns correctly. Illegal req_size=11 → error at E0+1.
